// File: rtl/ddr3_axil_reg_slave.sv
// AXI4-Lite register slave for the DDR3 interface control path: independent
// write and read FSMs over a small bank of byte-maskable control registers.
module ddr3_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic                         awready_q, awready_d, wready_q, wready_d;
    logic                         bvalid_q, bvalid_d, arready_q, arready_d;
    logic                         rvalid_q, rvalid_d;
    logic [1:0]                   bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0]                rdata_q, rdata_d, wdata_q, wdata_d;
    logic [SW-1:0]                wstrb_q, wstrb_d;
    logic [AW-1:0]                awaddr_q, awaddr_d;
    logic [NUM_REGS-1:0][DW-1:0]  regs_q, regs_d;

    logic          aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s;
    logic          waddr_ok_s, raddr_ok_s;
    logic [AW-1:0] waddr_s;
    logic [DW-1:0] wdata_s, rd_word_s;
    logic [SW-1:0] wstrb_s;
    logic          unused_s;

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return int'(addr[AW-1:2]) < NUM_REGS;
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
            else         res[8*b +: 8] = old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign aw_hs_s = S_AXI_AWVALID & awready_q;
    assign w_hs_s  = S_AXI_WVALID  & wready_q;
    assign b_hs_s  = bvalid_q & S_AXI_BREADY;
    assign ar_hs_s = S_AXI_ARVALID & arready_q;
    assign r_hs_s  = rvalid_q & S_AXI_RREADY;

    // Whichever half arrived first was latched; the other comes straight off the bus.
    assign waddr_s    = (wstate_q == W_WAIT_DATA) ? awaddr_q : S_AXI_AWADDR;
    assign wdata_s    = (wstate_q == W_WAIT_ADDR) ? wdata_q  : S_AXI_WDATA;
    assign wstrb_s    = (wstate_q == W_WAIT_ADDR) ? wstrb_q  : S_AXI_WSTRB;
    assign waddr_ok_s = addr_ok(waddr_s);
    assign raddr_ok_s = addr_ok(S_AXI_ARADDR);
    assign commit_s   = (wstate_d == W_RESP) && (wstate_q != W_RESP);
    assign unused_s   = ^{S_AXI_AWPROT, S_AXI_ARPROT, waddr_s[1:0], S_AXI_ARADDR[1:0]};

    // Write FSM next-state
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) wstate_d = W_RESP;
                else if (aw_hs_s)      wstate_d = W_WAIT_DATA;
                else if (w_hs_s)       wstate_d = W_WAIT_ADDR;
                else                   wstate_d = W_IDLE;
            end
            W_WAIT_DATA: wstate_d = w_hs_s  ? W_RESP : W_WAIT_DATA;
            W_WAIT_ADDR: wstate_d = aw_hs_s ? W_RESP : W_WAIT_ADDR;
            W_RESP:      wstate_d = b_hs_s  ? W_IDLE : W_RESP;
            default:     wstate_d = W_IDLE;
        endcase
    end

    // Read FSM next-state
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  rstate_d = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  rstate_d = r_hs_s  ? R_IDLE : R_DATA;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read mux over the current (pre-commit) register image
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word_s = rd_word_s | ((int'(S_AXI_ARADDR[AW-1:2]) == i) ? regs_q[i] : '0);
        end
    end

    // Register bank update on the completing write handshake
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (commit_s && waddr_ok_s && (int'(waddr_s[AW-1:2]) == i))
                        ? merge_bytes(regs_q[i], wdata_s, wstrb_s) : regs_q[i];
        end
    end

    // Output and capture next-state; handshake outputs follow the next FSM state
    always_comb begin
        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_ADDR);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_DATA);
        bvalid_d  = (wstate_d == W_RESP);
        bresp_d   = commit_s ? (waddr_ok_s ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
        rdata_d   = ar_hs_s ? (raddr_ok_s ? rd_word_s : '0) : rdata_q;
        rresp_d   = ar_hs_s ? (raddr_ok_s ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        awaddr_d  = aw_hs_s ? S_AXI_AWADDR : awaddr_q;
        wdata_d   = w_hs_s  ? S_AXI_WDATA  : wdata_q;
        wstrb_d   = w_hs_s  ? S_AXI_WSTRB  : wstrb_q;
    end

    // State, outputs and register bank; reset drops any in-flight transaction
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            regs_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_q         = regs_q;

endmodule
